// File: rtl/imm_gen_pipe_pkg.sv
// imm_gen_pipe_pkg: shared RISC-V opcode constants and immediate format encodings
package imm_gen_pipe_pkg;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  typedef enum logic [2:0] {
    FMT_NONE  = 3'd0,
    FMT_I     = 3'd1,
    FMT_S     = 3'd2,
    FMT_B     = 3'd3,
    FMT_U     = 3'd4,
    FMT_J     = 3'd5,
    FMT_SHAMT = 3'd6
  } imm_fmt_t;
endpackage

// File: rtl/imm_gen_pipe_decode.sv
// imm_decode: combinational immediate extraction and format classification
module imm_decode
  import imm_gen_pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instruction,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt,
  output logic            illegal
);
  logic [6:0] op;
  logic [31:0] shamt;
  logic [31:0] imm32;
  imm_fmt_t f;
  assign op = instruction[6:0];
  assign shamt = XLEN == 64 ? {26'b0, instruction[25:20]} : {27'b0, instruction[24:20]};
  // classify the opcode, then assemble a 32-bit immediate that is sign-extended to XLEN
  always_comb begin
    f = op == OPC_OP_IMM ? (instruction[13:12] == 2'b01 ? FMT_SHAMT : FMT_I) :
        (op == OPC_LOAD || op == OPC_JALR || op == OPC_SYSTEM) ? FMT_I :
        op == OPC_STORE ? FMT_S :
        op == OPC_BRANCH ? FMT_B :
        (op == OPC_LUI || op == OPC_AUIPC) ? FMT_U :
        op == OPC_JAL ? FMT_J : FMT_NONE;
    imm32 = f == FMT_I ? {{20{instruction[31]}}, instruction[31:20]} :
            f == FMT_SHAMT ? shamt :
            f == FMT_S ? {{20{instruction[31]}}, instruction[31:25], instruction[11:7]} :
            f == FMT_B ? {{20{instruction[31]}}, instruction[7], instruction[30:25], instruction[11:8], 1'b0} :
            f == FMT_U ? {instruction[31:12], 12'b0} :
            f == FMT_J ? {{12{instruction[31]}}, instruction[19:12], instruction[20], instruction[30:21], 1'b0} : '0;
  end
  assign imm = XLEN'(signed'(imm32));
  assign fmt = f;
  assign illegal = f == FMT_NONE && op != OPC_OP;
endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: immediate decoder behind a 2-entry skid buffer with valid/ready handshakes
module imm_gen_pipe
  import imm_gen_pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instruction,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] imm_gen_out,
  output logic [2:0]      imm_fmt,
  output logic            imm_illegal
);
  localparam int EW = XLEN + 4;
  logic [XLEN-1:0] dec_imm;
  logic [2:0] dec_fmt;
  logic dec_ill;
  logic [EW-1:0] dec_e, main_q, skid_q;
  logic main_valid, skid_valid, accept;
  imm_decode #(.XLEN(XLEN)) u_decode (
    .instruction(instruction),
    .imm(dec_imm),
    .fmt(dec_fmt),
    .illegal(dec_ill)
  );
  assign dec_e = {dec_ill, dec_fmt, dec_imm};
  assign in_ready = !skid_valid;
  assign accept = in_valid && in_ready;
  assign out_valid = main_valid;
  assign {imm_illegal, imm_fmt, imm_gen_out} = main_valid ? main_q : '0;
  // main refills from skid first to keep FIFO order; skid only catches an accept during a stall
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (!main_valid || out_ready) begin
        main_valid <= skid_valid || accept;
        main_q <= skid_valid ? skid_q : dec_e;
      end
      if (main_valid && !out_ready && accept) begin
        skid_valid <= 1'b1;
        skid_q <= dec_e;
      end else if (main_valid && out_ready) begin
        skid_valid <= 1'b0;
      end
    end
  end
endmodule
